keypad_emulator: RTL

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/keypad_emulator.sv
// Emulates a 4x4 matrix keypad: a requested key is "pressed" with contact bounce,
// held closed for a given number of row-scan visits, then released with bounce.
module keypad_emulator #(
  parameter int BOUNCE_PERIOD  = 8,
  parameter int BOUNCE_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] key_code,
  input  logic [7:0] hold_scans,
  input  logic [3:0] keypadRow,
  output logic [3:0] keypadCol,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_BOUNCE,
    S_HOLD,
    S_RELEASE_BOUNCE
  } state_t;

  localparam bit         HAS_BOUNCE = (BOUNCE_TOGGLES > 0);
  localparam logic [15:0] PER_LAST  = 16'(BOUNCE_PERIOD - 1);
  localparam logic [7:0]  TOG_LAST  = 8'(BOUNCE_TOGGLES - 1);

  state_t      r_state;
  logic [3:0]  r_code;
  logic [7:0]  r_hold;
  logic [7:0]  r_hits;
  logic [3:0]  r_row_prev;
  logic        r_contact;
  logic        r_done;
  logic [15:0] r_cnt;
  logic [7:0]  r_phase;

  logic [3:0]  w_pos;
  logic [3:0]  w_row_tgt;
  logic [3:0]  w_col_tgt;
  logic        w_row_match;
  logic        w_hit;

  // Key code -> {row index, column index}; row n is strobed by keypadRow[n] low.
  function automatic logic [3:0] f_key_pos(input logic [3:0] code);
    logic [3:0] pos;
    case (code)
      4'h7: pos = {2'd0, 2'd0};
      4'h4: pos = {2'd0, 2'd1};
      4'h1: pos = {2'd0, 2'd2};
      4'h0: pos = {2'd0, 2'd3};
      4'h8: pos = {2'd1, 2'd0};
      4'h5: pos = {2'd1, 2'd1};
      4'h2: pos = {2'd1, 2'd2};
      4'hA: pos = {2'd1, 2'd3};
      4'h9: pos = {2'd2, 2'd0};
      4'h6: pos = {2'd2, 2'd1};
      4'h3: pos = {2'd2, 2'd2};
      4'hB: pos = {2'd2, 2'd3};
      4'hC: pos = {2'd3, 2'd0};
      4'hD: pos = {2'd3, 2'd1};
      4'hE: pos = {2'd3, 2'd2};
      default: pos = {2'd3, 2'd3};
    endcase
    return pos;
  endfunction

  assign w_pos       = f_key_pos(r_code);
  assign w_row_tgt   = ~(4'b0001 << w_pos[3:2]);
  assign w_col_tgt   = ~(4'b0001 << w_pos[1:0]);
  assign w_row_match = (keypadRow == w_row_tgt);
  assign w_hit       = w_row_match && (r_row_prev != w_row_tgt);

  assign key_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

  // The target row is one-hot low, so malformed strobes can never match it.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    keypadCol = 4'b1111;
    if (r_contact && w_row_match) keypadCol = w_col_tgt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_code     <= 4'h0;
      r_hold     <= 8'd0;
      r_hits     <= 8'd0;
      r_row_prev <= 4'b1111;
      r_contact  <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= 16'd0;
      r_phase    <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_row_prev <= keypadRow;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (key_valid && key_ready) begin
            r_code    <= key_code;
            r_hold    <= (hold_scans == 8'd0) ? 8'd1 : hold_scans;
            r_hits    <= 8'd0;
            r_contact <= 1'b1;
            r_cnt     <= 16'd0;
            r_phase   <= 8'd0;
            r_state   <= HAS_BOUNCE ? S_PRESS_BOUNCE : S_HOLD;
          end
        end
        S_PRESS_BOUNCE: begin
          if (r_cnt == PER_LAST) begin
            r_cnt <= 16'd0;
            if (r_phase == TOG_LAST) begin
              r_contact <= 1'b1;
              r_state   <= S_HOLD;
            end else begin
              r_phase   <= r_phase + 8'd1;
              r_contact <= r_phase[0];  // next phase even -> closed
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_HOLD: begin
          if (w_hit && r_hits != 8'hFF) r_hits <= r_hits + 8'd1;
          // Leaving only once the row moves away keeps the last dwell whole.
          if (r_hits >= r_hold && !w_row_match) begin
            r_contact <= 1'b0;
            r_cnt     <= 16'd0;
            r_phase   <= 8'd0;
            if (HAS_BOUNCE) begin
              r_state <= S_RELEASE_BOUNCE;
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RELEASE_BOUNCE: begin
          if (r_cnt == PER_LAST) begin
            r_cnt <= 16'd0;
            if (r_phase == TOG_LAST) begin
              r_contact <= 1'b0;
              r_state   <= S_IDLE;
              r_done    <= 1'b1;
            end else begin
              r_phase   <= r_phase + 8'd1;
              r_contact <= ~r_phase[0];  // next phase odd -> closed
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
